// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    localparam int MUL_W = 32;

    // Number of BUSY cycles needed to retire all multiplier bits.
    function automatic int n_iter(input int iter_bits);
        return MUL_W / iter_bits;
    endfunction

endpackage

// File: rtl/is_zero32.sv
// 32-bit zero detector used for the product flags.
module is_zero32 (
    input  logic [31:0] din,
    output logic        is_zero
);

    assign is_zero = (din == 32'd0);

endmodule

// File: rtl/seq_mul32.sv
// Iterative 32x32 unsigned shift-add multiplier with valid/ready on both sides.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready = 1
// BUSY  | retiring ITER_BITS multiplier bits per cycle
// DONE  | product held on prod_hi/prod_lo, out_valid = 1 until out_ready
module seq_mul32
    import mul_pkg::*;
#(
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] prod_lo,
    output logic [31:0] prod_hi,
    output logic        lo_zero,
    output logic        zero
);

    localparam int N_ITER = n_iter(ITER_BITS);
    localparam int CNT_W  = 6;
    // Accumulator plus room for the ITER_BITS shifted copies of the multiplicand.
    localparam int SUM_W  = MUL_W + 1 + ITER_BITS;

    mul_state_t        state_q, state_d;
    logic [MUL_W-1:0]  mcand_q, mcand_d;
    logic [MUL_W-1:0]  mplier_q, mplier_d;
    logic [MUL_W:0]    acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [SUM_W-1:0]  addend;
    logic [SUM_W-1:0]  sum;
    logic              hi_zero;

    // Sum of the multiplicand copies selected by the low multiplier bits, added to the accumulator.
    always_comb begin
        addend = '0;
        for (int j = 0; j < ITER_BITS; j++) begin
            if (mplier_q[j]) begin
                addend = addend + (SUM_W'(mcand_q) << j);
            end
        end
        sum = SUM_W'(acc_q) + addend;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = BUSY;
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                // Shift {sum, multiplier} right: low sum bits become product low bits.
                acc_d    = sum[SUM_W-1:ITER_BITS];
                mplier_d = {sum[ITER_BITS-1:0], mplier_q[MUL_W-1:ITER_BITS]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign prod_lo   = mplier_q;
    assign prod_hi   = acc_q[MUL_W-1:0];

    is_zero32 u_lo_zero (
        .din     (prod_lo),
        .is_zero (lo_zero)
    );

    is_zero32 u_hi_zero (
        .din     (prod_hi),
        .is_zero (hi_zero)
    );

    assign zero = lo_zero & hi_zero;

endmodule
